// File: rtl/cp0_ctrl_pkg.sv
// Shared constants for the CP0 command initiator: role codes, request kinds,
// FSM state encoding and the default exception entry address.
package cp0_pkg;

  localparam logic [2:0] ROLE_MFC0    = 3'b000;
  localparam logic [2:0] ROLE_MTC0    = 3'b001;
  localparam logic [2:0] ROLE_BREAK   = 3'b010;
  localparam logic [2:0] ROLE_SYSCALL = 3'b011;
  localparam logic [2:0] ROLE_TEQ     = 3'b100;
  localparam logic [2:0] ROLE_ERET    = 3'b101;

  localparam logic [2:0] KIND_MFC0    = 3'd0;
  localparam logic [2:0] KIND_MTC0    = 3'd1;
  localparam logic [2:0] KIND_BREAK   = 3'd2;
  localparam logic [2:0] KIND_SYSCALL = 3'd3;
  localparam logic [2:0] KIND_TEQ     = 3'd4;
  localparam logic [2:0] KIND_ERET    = 3'd5;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0040_0004;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_FINISH
  } state_t;

  function automatic logic [2:0] kind_to_role(input logic [2:0] kind);
    case (kind)
      KIND_MTC0:    kind_to_role = ROLE_MTC0;
      KIND_BREAK:   kind_to_role = ROLE_BREAK;
      KIND_SYSCALL: kind_to_role = ROLE_SYSCALL;
      KIND_TEQ:     kind_to_role = ROLE_TEQ;
      KIND_ERET:    kind_to_role = ROLE_ERET;
      default:      kind_to_role = ROLE_MFC0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// Bundle of the decode-side request/response and CP0 command signals.
// slave = the cp0_ctrl initiator, master = datapath plus CP0 environment.
interface cp0_ctrl_if #(parameter int ROLE_W = 3);
  logic              req_valid;
  logic [2:0]        req_kind;
  logic [31:0]       req_pc;
  logic [4:0]        req_sel;
  logic [31:0]       req_wdata;
  logic              teq_equal;
  logic [31:0]       cp0_outdata;
  logic [ROLE_W-1:0] cp0_role;
  logic [4:0]        cp0_sel;
  logic [31:0]       cp0_data_in;
  logic              stall;
  logic              done;
  logic [31:0]       rd_data;
  logic              redirect;
  logic [31:0]       redirect_pc;

  modport slave (
    input  req_valid, req_kind, req_pc, req_sel, req_wdata, teq_equal, cp0_outdata,
    output cp0_role, cp0_sel, cp0_data_in, stall, done, rd_data, redirect, redirect_pc
  );

  modport master (
    output req_valid, req_kind, req_pc, req_sel, req_wdata, teq_equal, cp0_outdata,
    input  cp0_role, cp0_sel, cp0_data_in, stall, done, rd_data, redirect, redirect_pc
  );
endinterface

// File: rtl/cp0_ctrl.sv
// CPU-side CP0 command initiator: IDLE -> ISSUE -> CAPTURE -> FINISH sequencing.
// Optional CP0_CTRL_EXC_CNT_EN adds a saturating exc_count of handler redirects.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter int          ROLE_W       = 3
) (
  input logic        clk,
  input logic        rst,
  cp0_ctrl_if.slave  bus
`ifdef CP0_CTRL_EXC_CNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  state_t            r_state;
  logic [2:0]        r_kind;
  logic [ROLE_W-1:0] r_role;
  logic [4:0]        r_sel;
  logic [31:0]       r_data;
  logic              r_done;
  logic              r_redirect;
  logic [31:0]       r_rd_data;
  logic [31:0]       r_redirect_pc;
  logic              w_skip;
  logic              w_is_exc;
`ifdef CP0_CTRL_EXC_CNT_EN
  logic [15:0]       r_exc_count;
`endif

  // Untaken teq and illegal kinds finish without touching CP0.
  assign w_skip = ((bus.req_kind == KIND_TEQ) && !bus.teq_equal) || (bus.req_kind > KIND_ERET);
  assign w_is_exc = (r_kind == KIND_BREAK) || (r_kind == KIND_SYSCALL) || (r_kind == KIND_TEQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_kind        <= KIND_MFC0;
      r_role        <= '0;
      r_sel         <= '0;
      r_data        <= '0;
      r_done        <= 1'b0;
      r_redirect    <= 1'b0;
      r_rd_data     <= '0;
      r_redirect_pc <= '0;
`ifdef CP0_CTRL_EXC_CNT_EN
      r_exc_count   <= '0;
`endif
    end else begin
      r_role     <= ROLE_W'(ROLE_MFC0);
      r_sel      <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_kind <= bus.req_kind;
            if (w_skip) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              // The command is registered here so it appears on the bus during ISSUE.
              r_state <= ST_ISSUE;
              r_role  <= ROLE_W'(kind_to_role(bus.req_kind));
              if (bus.req_kind == KIND_MFC0 || bus.req_kind == KIND_MTC0)
                r_sel <= bus.req_sel;
              if (bus.req_kind == KIND_MTC0)
                r_data <= bus.req_wdata;
              else if (bus.req_kind >= KIND_BREAK && bus.req_kind <= KIND_TEQ)
                r_data <= bus.req_pc;
            end
          end
        end
        ST_ISSUE: begin
          if (r_kind == KIND_MFC0 || r_kind == KIND_ERET) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
            if (w_is_exc) begin
              r_redirect    <= 1'b1;
              r_redirect_pc <= HANDLER_ADDR;
            end
          end
        end
        ST_CAPTURE: begin
          r_state <= ST_FINISH;
          r_done  <= 1'b1;
          if (r_kind == KIND_MFC0) begin
            r_rd_data <= bus.cp0_outdata;
          end else begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= bus.cp0_outdata;
          end
        end
        default: begin
          r_state <= ST_IDLE;
`ifdef CP0_CTRL_EXC_CNT_EN
          if (r_redirect && w_is_exc && r_exc_count != 16'hFFFF)
            r_exc_count <= r_exc_count + 16'd1;
`endif
        end
      endcase
    end
  end

  // Stall rises combinationally with the request so decode freezes in the accept cycle.
  assign bus.stall       = (r_state != ST_IDLE) || (bus.req_valid && rst);
  assign bus.cp0_role    = r_role;
  assign bus.cp0_sel     = r_sel;
  assign bus.cp0_data_in = r_data;
  assign bus.done        = r_done;
  assign bus.redirect    = r_redirect;
  assign bus.rd_data     = r_rd_data;
  assign bus.redirect_pc = r_redirect_pc;
`ifdef CP0_CTRL_EXC_CNT_EN
  assign exc_count = r_exc_count;
`endif

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed test-plan ops, then randomized ops
// checked every cycle against a transaction-level latency/result model.
module tb_cp0_ctrl;
   import cp0_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cp0_ctrl_if bus ();
`ifdef CP0_CTRL_EXC_CNT_EN
   logic [15:0] excCount;
`endif

   cp0_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef CP0_CTRL_EXC_CNT_EN
      ,
      .exc_count (excCount)
`endif
   );

   int checks = 0;
   int errors = 0;

   // CP0 environment: registered read port, writes from mtc0, EPC from exceptions.
   logic [31:0] cp0Regs [32];
   logic        bdWe = 1'b0;
   logic [4:0]  bdAddr = '0;
   logic [31:0] bdData = '0;
   always @(posedge clk) begin
      if (bdWe)
         cp0Regs[bdAddr] <= bdData;
      else if (bus.cp0_role == ROLE_MTC0)
         cp0Regs[bus.cp0_sel] <= bus.cp0_data_in;
      else if (bus.cp0_role == ROLE_BREAK || bus.cp0_role == ROLE_SYSCALL || bus.cp0_role == ROLE_TEQ)
         cp0Regs[14] <= bus.cp0_data_in;
      bus.cp0_outdata <= (bus.cp0_role == ROLE_ERET) ? cp0Regs[14] : cp0Regs[bus.cp0_sel];
   end

   // Architectural shadow of CP0 contents, updated from the requests themselves.
   logic [31:0] shadow [32];
   int          expCnt = 0;

   logic        expActive = 1'b0;
   int          expT = -1;
   logic        expStall, expDone, expRedir, expChkSel, expChkData, expChkRpc;
   logic [2:0]  expRole;
   logic [4:0]  expSel;
   logic [31:0] expData, expRpc, expRd;

   int          obsDoneT;
   logic        obsRedir;
   logic [31:0] obsRpc, obsIssueData;
   logic [2:0]  obsIssueRole;
   logic [4:0]  obsIssueSel;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (expActive) begin
         checkOutput("stall", 32'(bus.stall), 32'(expStall));
         checkOutput("done", 32'(bus.done), 32'(expDone));
         checkOutput("redirect", 32'(bus.redirect), 32'(expRedir));
         checkOutput("cp0_role", 32'(bus.cp0_role), 32'(expRole));
         checkOutput("rd_data", bus.rd_data, expRd);
         if (expChkSel) checkOutput("cp0_sel", 32'(bus.cp0_sel), 32'(expSel));
         if (expChkData) checkOutput("cp0_data_in", bus.cp0_data_in, expData);
         if (expChkRpc) checkOutput("redirect_pc", bus.redirect_pc, expRpc);
         if (bus.done) obsDoneT = expT;
         if (bus.redirect) begin
            obsRedir = 1'b1;
            obsRpc   = bus.redirect_pc;
         end
         if (expT == 1) begin
            obsIssueRole = bus.cp0_role;
            obsIssueSel  = bus.cp0_sel;
            obsIssueData = bus.cp0_data_in;
         end
      end
   end

   task automatic setIdleExp();
      expT       = -1;
      expStall   = 1'b0;
      expDone    = 1'b0;
      expRedir   = 1'b0;
      expRole    = ROLE_MFC0;
      expChkSel  = 1'b1;
      expSel     = '0;
      expChkData = 1'b0;
      expChkRpc  = 1'b0;
   endtask

   task automatic bdWrite(input logic [4:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      bdWe = 1'b1; bdAddr = addr; bdData = data;
      shadow[addr] = data;
      @(posedge clk); #1;
      bdWe = 1'b0;
   endtask

   // One request; the model derives latency and results from the operation rules.
   task automatic applyStimulus(input logic [2:0] kind, input logic [31:0] pc, input logic [4:0] sel,
                                input logic [31:0] wdata, input logic teq, input logic b2b);
      logic issue, redir;
      int lat;
      logic [31:0] rpc;
      issue = (kind <= KIND_ERET) && !(kind == KIND_TEQ && !teq);
      lat   = !issue ? 1 : ((kind == KIND_MFC0 || kind == KIND_ERET) ? 3 : 2);
      redir = issue && (kind >= KIND_BREAK);
      rpc   = (kind == KIND_ERET) ? shadow[14] : 32'h0040_0004;
      if (!b2b) begin
         @(posedge clk); #1;
      end
      obsDoneT = -1; obsRedir = 1'b0; obsRpc = '0;
      obsIssueRole = '1; obsIssueSel = '1; obsIssueData = '1;
      bus.req_valid = 1'b1; bus.req_kind = kind; bus.req_pc = pc;
      bus.req_sel = sel; bus.req_wdata = wdata; bus.teq_equal = teq;
      for (int t = 0; t <= lat; t++) begin
         expT       = t;
         expStall   = 1'b1;
         expDone    = (t == lat);
         expRedir   = (t == lat) && redir;
         expRole    = (t == 1 && issue) ? kind : ROLE_MFC0;
         expChkSel  = (t != 1) || (kind <= KIND_MTC0);
         expSel     = (t == 1) ? sel : 5'd0;
         expChkData = (t == 1) && issue && (kind >= KIND_MTC0) && (kind <= KIND_TEQ);
         expData    = (kind == KIND_MTC0) ? wdata : pc;
         expChkRpc  = (t == lat) && redir;
         expRpc     = rpc;
         if (t == lat && kind == KIND_MFC0) expRd = shadow[sel];
         @(posedge clk); #1;
         if (t == 0) begin
            bus.req_pc = $urandom; bus.req_sel = 5'($urandom); bus.req_wdata = $urandom;
            bus.teq_equal = 1'($urandom);
            if (kind > KIND_ERET) bus.req_kind = 3'($urandom);
         end
      end
      bus.req_valid = 1'b0;
      setIdleExp();
      if (issue && kind == KIND_MTC0) shadow[sel] = wdata;
      if (issue && kind >= KIND_BREAK && kind <= KIND_TEQ) begin
         shadow[14] = pc;
         if (expCnt != 65535) expCnt++;
      end
`ifdef CP0_CTRL_EXC_CNT_EN
      checkOutput("exc_count", 32'(excCount), 32'(expCnt));
`endif
   endtask

   initial begin
      rst = 1'b0;
      bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_pc = '0;
      bus.req_sel = '0; bus.req_wdata = '0; bus.teq_equal = 1'b0;
      expRd = '0;
      setIdleExp();
      for (int i = 0; i < 32; i++) bdWrite(5'(i), $urandom);
      checkOutput("reset_role", 32'(bus.cp0_role), 32'h0);
      checkOutput("reset_stall", 32'(bus.stall), 32'h0);
      checkOutput("reset_redirect_pc", bus.redirect_pc, 32'h0);
      @(negedge clk); rst = 1'b1;
      expActive = 1'b1;

      applyStimulus(KIND_MTC0, 32'h0040_0010, 5'd12, 32'h0000_0001, 1'b0, 1'b0);
      checkOutput("mtc0_latency", 32'(obsDoneT), 32'd2);
      checkOutput("mtc0_issue_role", 32'(obsIssueRole), 32'h1);
      checkOutput("mtc0_issue_sel", 32'(obsIssueSel), 32'd12);
      checkOutput("mtc0_issue_data", obsIssueData, 32'h1);
      checkOutput("mtc0_no_redirect", 32'(obsRedir), 32'h0);

      bdWrite(5'd14, 32'h0040_0120);
      applyStimulus(KIND_MFC0, 32'h0040_0014, 5'd14, 32'h0, 1'b0, 1'b0);
      checkOutput("mfc0_latency", 32'(obsDoneT), 32'd3);
      checkOutput("mfc0_issue_sel", 32'(obsIssueSel), 32'd14);
      checkOutput("mfc0_rd_data", bus.rd_data, 32'h0040_0120);

      applyStimulus(KIND_SYSCALL, 32'h0040_0050, 5'd3, 32'h0, 1'b0, 1'b1);
      checkOutput("syscall_latency", 32'(obsDoneT), 32'd2);
      checkOutput("syscall_issue_role", 32'(obsIssueRole), 32'h3);
      checkOutput("syscall_issue_data", obsIssueData, 32'h0040_0050);
      checkOutput("syscall_redirect_pc", obsRpc, 32'h0040_0004);

      applyStimulus(KIND_ERET, 32'h0040_0200, 5'd0, 32'h0, 1'b0, 1'b0);
      checkOutput("eret_latency", 32'(obsDoneT), 32'd3);
      checkOutput("eret_issue_role", 32'(obsIssueRole), 32'h5);
      checkOutput("eret_redirect_pc", obsRpc, 32'h0040_0050);

      applyStimulus(KIND_TEQ, 32'h0040_0058, 5'd0, 32'h0, 1'b0, 1'b1);
      checkOutput("teq_untaken_latency", 32'(obsDoneT), 32'd1);
      checkOutput("teq_untaken_redirect", 32'(obsRedir), 32'h0);
      applyStimulus(KIND_TEQ, 32'h0040_0060, 5'd0, 32'h0, 1'b1, 1'b0);
      checkOutput("teq_taken_role", 32'(obsIssueRole), 32'h4);
      checkOutput("teq_taken_redirect_pc", obsRpc, 32'h0040_0004);
      applyStimulus(3'd6, 32'h0040_0064, 5'd0, 32'h0, 1'b0, 1'b1);
      checkOutput("illegal_latency", 32'(obsDoneT), 32'd1);

      // Reset during the ISSUE cycle of a break.
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_kind = KIND_BREAK; bus.req_pc = 32'h0040_0070;
      expT = 0; expStall = 1'b1;
      @(posedge clk); #1;
      expT = 1; expRole = ROLE_BREAK; expChkSel = 1'b0;
      expChkData = 1'b1; expData = 32'h0040_0070;
      @(negedge clk); #1;
      expActive = 1'b0;
      rst = 1'b0; bus.req_valid = 1'b0;
      #1;
      checkOutput("abort_role", 32'(bus.cp0_role), 32'h0);
      checkOutput("abort_data", bus.cp0_data_in, 32'h0);
      checkOutput("abort_stall", 32'(bus.stall), 32'h0);
      checkOutput("abort_done", 32'(bus.done), 32'h0);
      checkOutput("abort_rd_data", bus.rd_data, 32'h0);
      @(posedge clk); #3;
      rst = 1'b1;
      expRd = '0; expCnt = 0;
      setIdleExp();
      expActive = 1'b1;

      applyStimulus(KIND_SYSCALL, 32'h0040_0080, 5'd0, 32'h0, 1'b0, 1'b0);
      applyStimulus(KIND_SYSCALL, 32'h0040_0084, 5'd0, 32'h0, 1'b0, 1'b1);
      applyStimulus(KIND_SYSCALL, 32'h0040_0088, 5'd0, 32'h0, 1'b0, 1'b0);
      applyStimulus(KIND_ERET, 32'h0040_008c, 5'd0, 32'h0, 1'b0, 1'b0);
      checkOutput("post_reset_eret_pc", obsRpc, 32'h0040_0088);
`ifdef CP0_CTRL_EXC_CNT_EN
      checkOutput("exc_count_three", 32'(excCount), 32'd3);
`endif

      for (int n = 0; n < 200; n++)
         applyStimulus(3'($urandom_range(0, 7)), $urandom, 5'($urandom), $urandom,
                       1'($urandom), 1'($urandom));

      @(posedge clk); #1;
      expActive = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
